// File: rtl/e_mdu.sv
// e_mdu - execute-stage multiply/divide unit.
//
// Owns the architectural HI/LO registers. It runs MULT/MULTU/DIV/DIVU as
// fixed-latency multi-cycle operations, and it performs MTHI/MTLO in a
// single cycle. While an operation runs, busy is held high so that the
// hazard unit can stall the next MDU instruction in D.
//
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU (ops 8/9).
// These accumulate a 64-bit product into {HI,LO}.
//
// Ports:
//   clk        pipeline clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      E-stage instruction is an MDU op
//   mdu_op     0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO,
//              6 MFHI, 7 MFLO, 8 MADD, 9 MADDU, others NOP
//   a, b       forwarded rs / rt operands
//   flush      E-stage cancel; beats start and commit
//   busy       multi-cycle operation in progress
//   done       one-cycle pulse when HI/LO are committed by a multi-cycle op
//   hi_lo_out  combinational HI (op 6) / LO (op 7) / 0 for the result mux
module e_mdu #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_lo_out
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
`endif

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [31:0] hi_r, hi_s, lo_r, lo_s;
    logic [31:0] shadow_hi_r, shadow_hi_s, shadow_lo_r, shadow_lo_s;
    logic        done_r, done_s;
    logic [63:0] calc_s;
    logic        launch_s;
    logic [3:0]  latency_s;

    // 64-bit product. The low 64 bits of an extended product are already
    // correct for the signed case, so a single unsigned multiplier serves both.
    function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = sgn ? {{32{x[31]}}, x} : {32'd0, x};
        ye = sgn ? {{32{y[31]}}, y} : {32'd0, y};
        return xe * ye;
    endfunction

    // Division on magnitudes. The result is {remainder, quotient}.
    // For a signed divide, the quotient is negated when the operand signs
    // differ, and the remainder takes the sign of the dividend.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    function automatic logic [63:0] div64(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        logic [31:0] mx, my, q, r;
        logic        neg_q, neg_r;
        neg_q = sgn & (x[31] ^ y[31]);
        neg_r = sgn & x[31];
        mx    = neg_r ? (32'd0 - x) : x;
        my    = (sgn & y[31]) ? (32'd0 - y) : y;
        if (y == 32'd0) begin
            return {x, 32'hFFFF_FFFF};
        end else begin
            q = mx / my;
            r = mx % my;
            q = neg_q ? (32'd0 - q) : q;
            r = neg_r ? (32'd0 - r) : r;
            return {r, q};
        end
    endfunction

    // Operation decode: result to be shadowed, launch flag and latency.
    always_comb begin
        calc_s    = 64'd0;
        launch_s  = 1'b0;
        latency_s = 4'd0;
        case (mdu_op)
            OP_MULT:  begin calc_s = mul64(a, b, 1'b1); launch_s = 1'b1; latency_s = 4'(MUL_CYCLES); end
            OP_MULTU: begin calc_s = mul64(a, b, 1'b0); launch_s = 1'b1; latency_s = 4'(MUL_CYCLES); end
            OP_DIV:   begin calc_s = div64(a, b, 1'b1); launch_s = 1'b1; latency_s = 4'(DIV_CYCLES); end
            OP_DIVU:  begin calc_s = div64(a, b, 1'b0); launch_s = 1'b1; latency_s = 4'(DIV_CYCLES); end
`ifdef MDU_MADD_EN
            // HI/LO are frozen while busy, so accumulating against their launch-time value is exact.
            OP_MADD:  begin calc_s = {hi_r, lo_r} + mul64(a, b, 1'b1); launch_s = 1'b1; latency_s = 4'(MUL_CYCLES); end
            OP_MADDU: begin calc_s = {hi_r, lo_r} + mul64(a, b, 1'b0); launch_s = 1'b1; latency_s = 4'(MUL_CYCLES); end
`endif
            default:  begin calc_s = 64'd0; launch_s = 1'b0; latency_s = 4'd0; end
        endcase
    end

    // Next-state logic: flush first, then idle launch/move, then busy countdown and commit.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        hi_s        = hi_r;
        lo_s        = lo_r;
        shadow_hi_s = shadow_hi_r;
        shadow_lo_s = shadow_lo_r;
        done_s      = 1'b0;
        if (flush) begin
            state_s     = ST_IDLE;
            cnt_s       = 4'd0;
            shadow_hi_s = 32'd0;
            shadow_lo_s = 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && launch_s) begin
                        state_s     = ST_BUSY;
                        cnt_s       = latency_s;
                        shadow_hi_s = calc_s[63:32];
                        shadow_lo_s = calc_s[31:0];
                    end else if (start && (mdu_op == OP_MTHI)) begin
                        hi_s = a;
                    end else if (start && (mdu_op == OP_MTLO)) begin
                        lo_s = a;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // The count reaches zero on this edge: commit the shadow result.
                    if (cnt_r <= 4'd1) begin
                        state_s = ST_IDLE;
                        cnt_s   = 4'd0;
                        hi_s    = shadow_hi_r;
                        lo_s    = shadow_lo_r;
                        done_s  = 1'b1;
                    end else begin
                        cnt_s = cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end
            endcase
        end
    end

    // State and architectural register update with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            shadow_hi_r <= 32'd0;
            shadow_lo_r <= 32'd0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            hi_r        <= hi_s;
            lo_r        <= lo_s;
            shadow_hi_r <= shadow_hi_s;
            shadow_lo_r <= shadow_lo_s;
            done_r      <= done_s;
        end
    end

    assign busy = (state_r == ST_BUSY);
    assign done = done_r;

    // MFHI/MFLO read port. It shows the current (pre-commit) HI/LO.
    always_comb begin
        hi_lo_out = 32'd0;
        case (mdu_op)
            OP_MFHI: hi_lo_out = hi_r;
            OP_MFLO: hi_lo_out = lo_r;
            default: hi_lo_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        rst_n, start, flush, rd_en;
    logic [3:0]  mdu_op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi_lo_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    string       rd_name_q[$];
    logic [31:0] rd_val_q[$];
    string       done_q[$];

    always #5 clk = ~clk;

    e_mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mdu_op    (mdu_op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi_lo_out (hi_lo_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match a queued expected commit,
    // and every read strobe is compared against the queued expected value.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_done: got done=1 expected done=0");
                end else begin
                    vec_cnt++;
                    void'(done_q.pop_front());
                end
            end
            if (rd_en === 1'b1 && rd_val_q.size() > 0) begin
                check(rd_name_q.pop_front(), hi_lo_out, rd_val_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        start = 1'b0;
        rd_en = 1'b1;
        mdu_op = 4'd6;
        rd_name_q.push_back({name, "_hi"});
        rd_val_q.push_back(eh);
        cyc();
        mdu_op = 4'd7;
        rd_name_q.push_back({name, "_lo"});
        rd_val_q.push_back(el);
        cyc();
        rd_en = 1'b0;
        mdu_op = 4'd15;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            cyc();
        end
    endtask

    task automatic launch(input string name, input logic [3:0] op, input logic [31:0] xa,
                          input logic [31:0] xb, input int nb,
                          input logic [31:0] eh, input logic [31:0] el);
        int n;
        start = 1'b1;
        mdu_op = op;
        a = xa;
        b = xb;
        if (nb > 0) done_q.push_back(name);
        cyc();
        start = 1'b0;
        mdu_op = 4'd15;
        count_busy(n);
        check({name, "_busy_cycles"}, 32'(n), 32'(nb));
        rd_hilo(name, eh, el);
    endtask

    task automatic move(input logic [3:0] op, input logic [31:0] xa);
        start = 1'b1;
        mdu_op = op;
        a = xa;
        cyc();
        start = 1'b0;
        mdu_op = 4'd15;
        check("move_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; rd_en = 1'b0;
        mdu_op = 4'd15; a = 32'd0; b = 32'd0;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        rd_hilo("reset", 32'd0, 32'd0);

        launch("mult_neg",  4'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        launch("divu",      4'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        launch("div_neg",   4'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        launch("div_zero",  4'd2, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF);
        launch("div_ovf",   4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        launch("multu_max", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);

        move(4'd4, 32'h1234_5678);
        check("mthi_busy_next", {31'd0, busy}, 32'd0);
        rd_hilo("mthi", 32'h1234_5678, 32'h0000_0001);

        // MULT 3*4 with a MTLO and a MULT issued while busy; both must be ignored.
        start = 1'b1; mdu_op = 4'd0; a = 32'd3; b = 32'd4;
        done_q.push_back("mult_inj");
        cyc();
        start = 1'b0; mdu_op = 4'd15;
        cyc();
        start = 1'b1; mdu_op = 4'd5; a = 32'hDEAD_BEEF;
        cyc();
        mdu_op = 4'd0; a = 32'd100; b = 32'd100;
        cyc();
        start = 1'b0; mdu_op = 4'd15;
        count_busy(n);
        check("mult_inj_remaining_busy", 32'(n), 32'd2);
        rd_hilo("mult_inj", 32'd0, 32'd12);

        // MULTU aborted by flush in the third busy cycle.
        start = 1'b1; mdu_op = 4'd1; a = 32'd2; b = 32'd3;
        cyc();
        start = 1'b0; mdu_op = 4'd15;
        cyc(); cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 8; i++) cyc();
        rd_hilo("flush", 32'd0, 32'd12);

        // flush together with start launches nothing.
        start = 1'b1; flush = 1'b1; mdu_op = 4'd0; a = 32'd5; b = 32'd5;
        cyc();
        start = 1'b0; flush = 1'b0; mdu_op = 4'd15;
        check("flush_start_busy", {31'd0, busy}, 32'd0);
        rd_hilo("flush_start", 32'd0, 32'd12);

        launch("nop_op12", 4'd12, 32'd9, 32'd9, 0, 32'd0, 32'd12);

        // Reset asserted in the third busy cycle clears everything immediately.
        start = 1'b1; mdu_op = 4'd1; a = 32'd2; b = 32'd3;
        cyc();
        start = 1'b0; mdu_op = 4'd15;
        cyc(); cyc();
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        rd_hilo("rst_mid", 32'd0, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        check("rst_after_busy", {31'd0, busy}, 32'd0);

        move(4'd4, 32'd0);
        move(4'd5, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        launch("maddu", 4'd9, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
        launch("maddu_off", 4'd9, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF);
`endif

        cyc(); cyc();
        check("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
